// File: rtl/upsample_pkg.sv
// Shared types, region codes and size decoding for the 2x upsampling sequencer.
package upsample_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int LOG2_W = 3;

  localparam logic [3:0] REGION_TL = 4'd0;
  localparam logic [3:0] REGION_T  = 4'd1;
  localparam logic [3:0] REGION_TR = 4'd2;
  localparam logic [3:0] REGION_L  = 4'd3;
  localparam logic [3:0] REGION_IN = 4'd4;
  localparam logic [3:0] REGION_R  = 4'd5;
  localparam logic [3:0] REGION_BL = 4'd6;
  localparam logic [3:0] REGION_B  = 4'd7;
  localparam logic [3:0] REGION_BR = 4'd8;

  localparam logic [2:0] MAX_SIZE_SEL = 3'd4;

  function automatic logic size_legal(input logic [2:0] sel);
    return sel <= MAX_SIZE_SEL;
  endfunction

  // Output side is 8 << sel, so log2(side) = sel + 3; illegal codes map to the smallest size.
  function automatic logic [LOG2_W-1:0] size_log2(input logic [2:0] sel);
    return size_legal(sel) ? (sel + 3'd3) : 3'd3;
  endfunction

endpackage

// File: rtl/upsample_raster_counter.sv
// Three-level col/row/channel raster counter; steps one pixel per advance.
module upsample_raster_counter
  import upsample_pkg::*;
#(
  parameter int MAX_LOG2 = 7,
  parameter int CH_W     = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                advance,
  input  logic [LOG2_W-1:0]   log2,
  input  logic [CH_W-1:0]     num_ch,
  output logic [MAX_LOG2-1:0] col,
  output logic [MAX_LOG2-1:0] row,
  output logic [CH_W-1:0]     ch,
  output logic                col_last,
  output logic                row_last,
  output logic                last_beat
);

  logic [MAX_LOG2:0]   side;
  logic [MAX_LOG2-1:0] max_idx;

  assign side      = (MAX_LOG2+1)'(1) << log2;
  assign max_idx   = MAX_LOG2'(side - (MAX_LOG2+1)'(1));
  assign col_last  = (col == max_idx);
  assign row_last  = (row == max_idx);
  assign last_beat = col_last && row_last && (ch == num_ch - CH_W'(1));

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      col <= '0;
      row <= '0;
      ch  <= '0;
    end else if (advance) begin
      if (col_last) begin
        col <= '0;
        if (row_last) begin
          row <= '0;
          ch  <= ch + CH_W'(1);
        end else begin
          row <= row + MAX_LOG2'(1);
        end
      end else begin
        col <= col + MAX_LOG2'(1);
      end
    end
  end

endmodule

// File: rtl/upsample_addr_gen.sv
// 2x upsampling address sequencer: FSM, shift-based address generation,
// border-region decode and registered valid/ready beat outputs.
module upsample_addr_gen
  import upsample_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int MAX_LOG2 = 7,
  parameter int CH_W     = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        size_sel,
  input  logic [CH_W-1:0]   num_ch,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W-1:0] in_addr,
  output logic [CH_W-1:0]   ch_idx,
  output logic [3:0]        region,
  output logic              row_even,
  output logic              col_even,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t              state;
  logic [LOG2_W-1:0]   log2_q;
  logic                size_ok_q;
  logic [CH_W-1:0]     num_ch_q;

  logic [MAX_LOG2-1:0] col, row;
  logic [CH_W-1:0]     ch;
  logic                col_last, row_last, last_beat;
  logic                advance, clear;

  logic [MAX_LOG2:0]   side;
  logic [MAX_LOG2-1:0] max_idx;
  logic [MAX_LOG2-1:0] src_col, src_row;
  logic [CH_W-1:0]     src_ch;
  logic [ADDR_W-1:0]   nxt_out_addr, nxt_in_addr;
  logic [3:0]          nxt_region;

  function automatic logic [3:0] region_code(input logic top, input logic bottom,
                                             input logic left, input logic right);
    logic [3:0] base;
    base = top ? REGION_TL : (bottom ? REGION_BL : REGION_L);
    return base + (left ? 4'd0 : (right ? 4'd2 : 4'd1));
  endfunction

  assign advance = (state == ST_RUN) && out_ready;
  assign clear   = (state == ST_LOAD);

  upsample_raster_counter #(
    .MAX_LOG2 (MAX_LOG2),
    .CH_W     (CH_W)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .advance   (advance),
    .log2      (log2_q),
    .num_ch    (num_ch_q),
    .col       (col),
    .row       (row),
    .ch        (ch),
    .col_last  (col_last),
    .row_last  (row_last),
    .last_beat (last_beat)
  );

  assign side    = (MAX_LOG2+1)'(1) << log2_q;
  assign max_idx = MAX_LOG2'(side - (MAX_LOG2+1)'(1));

  // Output registers always hold the beat being offered, so they load the
  // position the counter moves to: origin in LOAD, successor on a handshake.
  always_comb begin
    src_col = '0;
    src_row = '0;
    src_ch  = '0;
    if (state != ST_LOAD) begin
      src_col = col_last ? '0 : col + MAX_LOG2'(1);
      src_row = col_last ? (row_last ? '0 : row + MAX_LOG2'(1)) : row;
      src_ch  = (col_last && row_last) ? ch + CH_W'(1) : ch;
    end
  end

  assign nxt_out_addr = (ADDR_W'(src_row) << log2_q) | ADDR_W'(src_col);
  assign nxt_in_addr  = (ADDR_W'(src_row >> 1) << (log2_q - 3'd1)) | ADDR_W'(src_col >> 1);
  assign nxt_region   = region_code(src_row == '0, src_row == max_idx,
                                    src_col == '0, src_col == max_idx);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      log2_q    <= '0;
      size_ok_q <= 1'b0;
      num_ch_q  <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      in_addr   <= '0;
      ch_idx    <= '0;
      region    <= '0;
      row_even  <= 1'b0;
      col_even  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_LOAD;
            busy      <= 1'b1;
            log2_q    <= size_log2(size_sel);
            size_ok_q <= size_legal(size_sel);
            num_ch_q  <= num_ch;
          end
        end
        ST_LOAD: begin
          if (!size_ok_q) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else if (num_ch_q == '0) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= ST_RUN;
            out_valid <= 1'b1;
            out_addr  <= nxt_out_addr;
            in_addr   <= nxt_in_addr;
            ch_idx    <= src_ch;
            region    <= nxt_region;
            row_even  <= ~src_row[0];
            col_even  <= ~src_col[0];
          end
        end
        ST_RUN: begin
          if (out_ready) begin
            if (last_beat) begin
              state     <= ST_DONE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_addr <= nxt_out_addr;
              in_addr  <= nxt_in_addr;
              ch_idx   <= src_ch;
              region   <= nxt_region;
              row_even <= ~src_row[0];
              col_even <= ~src_col[0];
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_upsample_addr_gen.sv
// Directed bench for upsample_addr_gen with hand-computed expected beats.
module tb_upsample_addr_gen;

  localparam int ADDR_W   = 14;
  localparam int MAX_LOG2 = 7;
  localparam int CH_W     = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [2:0]        size_sel;
  logic [CH_W-1:0]   num_ch;
  logic              out_ready;
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic [ADDR_W-1:0] in_addr;
  logic [CH_W-1:0]   ch_idx;
  logic [3:0]        region;
  logic              row_even;
  logic              col_even;
  logic              busy;
  logic              done;
  logic              err;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  upsample_addr_gen #(
    .ADDR_W   (ADDR_W),
    .MAX_LOG2 (MAX_LOG2),
    .CH_W     (CH_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .size_sel  (size_sel),
    .num_ch    (num_ch),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .in_addr   (in_addr),
    .ch_idx    (ch_idx),
    .region    (region),
    .row_even  (row_even),
    .col_even  (col_even),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Leaves the bench 1ns after the edge that sampled start (DUT now in LOAD).
  task automatic do_start(input logic [2:0] sel, input logic [CH_W-1:0] nch);
    start    = 1'b1;
    size_sel = sel;
    num_ch   = nch;
    tick();
    start    = 1'b0;
  endtask

  // Counts offered beats with ready high until done; one extra cycle lets the FSM reach IDLE.
  task automatic run_to_done(input int bound, output int beats, output bit ok);
    beats = 0;
    ok    = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (out_valid) beats++;
    end
    tick();
  endtask

  initial begin
    int          beats;
    bit          ok;
    int          k;
    bit          prev_stall;
    bit          seen_done;
    logic [ADDR_W-1:0] s_addr, s_in;
    logic [CH_W-1:0]   s_ch;
    logic [3:0]        s_reg;
    int          pix, prow, pcol;

    rst = 1'b0; start = 1'b0; size_sel = '0; num_ch = '0; out_ready = 1'b0;
    repeat (2) tick();
    check("rst_valid", out_valid, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_err",   err, 0);
    check("rst_oaddr", out_addr, 0);
    check("rst_iaddr", in_addr, 0);
    check("rst_region", region, 0);
    check("rst_ch",    ch_idx, 0);
    check("rst_par",   {row_even, col_even}, 0);
    rst = 1'b1;
    tick();

    // 8x8, one channel, ready always high.
    out_ready = 1'b1;
    do_start(3'd0, 9'd1);
    check("t1_load_busy",  busy, 1);
    check("t1_load_valid", out_valid, 0);
    beats = 0;
    for (int b = 0; b < 64; b++) begin
      tick();
      if (out_valid) beats++;
      if (b == 0) begin
        check("t1_b0_oaddr", out_addr, 0);
        check("t1_b0_iaddr", in_addr, 0);
        check("t1_b0_region", region, 0);
        check("t1_b0_par", {row_even, col_even}, 2'b11);
      end
      if (b == 7) check("t1_b7_region", region, 2);
      if (b == 29) begin
        check("t1_b29_oaddr", out_addr, 29);
        check("t1_b29_iaddr", in_addr, 6);
        check("t1_b29_region", region, 4);
        check("t1_b29_par", {row_even, col_even}, 2'b00);
      end
      if (b == 63) begin
        check("t1_b63_oaddr", out_addr, 63);
        check("t1_b63_region", region, 8);
      end
    end
    check("t1_beats", beats, 64);
    // 65 edges after the start-sampling edge: LOAD + 64 handshakes.
    tick();
    check("t1_done", done, 1);
    check("t1_done_busy", busy, 0);
    check("t1_done_valid", out_valid, 0);
    tick();
    check("t1_done_pulse", done, 0);

    // 16x16, three channels, random back-pressure.
    do_start(3'd1, 9'd3);
    k = 0;
    prev_stall = 1'b0;
    seen_done = 1'b0;
    s_addr = '0; s_in = '0; s_ch = '0; s_reg = '0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (prev_stall) begin
        check("t2_hold_valid",  out_valid, 1);
        check("t2_hold_oaddr",  out_addr, s_addr);
        check("t2_hold_iaddr",  in_addr, s_in);
        check("t2_hold_ch",     ch_idx, s_ch);
        check("t2_hold_region", region, s_reg);
      end
      out_ready = ($urandom_range(0, 1) == 1);
      if (out_valid) begin
        pix  = k % 256;
        prow = pix / 16;
        pcol = pix % 16;
        check("t2_oaddr", out_addr, pix);
        check("t2_iaddr", in_addr, (prow / 2) * 8 + pcol / 2);
        check("t2_ch",    ch_idx, k / 256);
        if (out_ready) k++;
      end
      prev_stall = out_valid && !out_ready;
      s_addr = out_addr; s_in = in_addr; s_ch = ch_idx; s_reg = region;
    end
    check("t2_done_seen", seen_done, 1);
    check("t2_accepted", k, 768);
    out_ready = 1'b1;
    tick();

    // Illegal size, then a legal run.
    do_start(3'd5, 9'd1);
    tick();
    check("t3_err", err, 1);
    check("t3_err_valid", out_valid, 0);
    check("t3_err_busy", busy, 0);
    tick();
    check("t3_err_pulse", err, 0);
    check("t3_no_valid", out_valid, 0);
    do_start(3'd0, 9'd1);
    run_to_done(500, beats, ok);
    check("t3_after_done", ok, 1);
    check("t3_after_beats", beats, 64);

    // Zero channels.
    do_start(3'd2, 9'd0);
    tick();
    check("t4_done", done, 1);
    check("t4_valid", out_valid, 0);
    tick();
    check("t4_done_pulse", done, 0);
    check("t4_busy", busy, 0);

    // Reset in the middle of a 128x128 run.
    do_start(3'd4, 9'd1);
    repeat (21) tick();
    check("t5_b20_oaddr", out_addr, 20);
    check("t5_b20_iaddr", in_addr, 10);
    check("t5_b20_region", region, 1);
    rst = 1'b0;
    tick();
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_oaddr", out_addr, 0);
    check("t5_rst_iaddr", in_addr, 0);
    check("t5_rst_region", region, 0);
    check("t5_rst_busy", busy, 0);
    rst = 1'b1;
    do_start(3'd0, 9'd2);
    tick();
    check("t5_new_valid", out_valid, 1);
    check("t5_new_oaddr", out_addr, 0);
    check("t5_new_ch", ch_idx, 0);
    // First beat already observed above, so 2*64-1 remain.
    run_to_done(1000, beats, ok);
    check("t5_new_done", ok, 1);
    check("t5_new_beats", beats, 127);

    // Start pulsed mid-run with a different size and channel count.
    do_start(3'd0, 9'd1);
    beats = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      start    = (i == 5);
      size_sel = (i == 5) ? 3'd2 : 3'd0;
      num_ch   = (i == 5) ? 9'd4 : 9'd1;
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (out_valid) beats++;
    end
    start = 1'b0;
    check("t6_done", ok, 1);
    check("t6_beats", beats, 64);
    tick();
    check("t6_idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
